nibble_serial_sub16: RTL and testbench



---
 rtl/nibble_serial_sub16_if.sv | 25 ++
 rtl/nibble_serial_sub16.sv | 115 +++++++++++
 tb/tb_nibble_serial_sub16.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_sub16_if.sv
// rtl/nibble_serial_sub16_if.sv - operand/result handshake bundle for nibble_serial_sub16
interface nibble_serial_sub16_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/nibble_serial_sub16.sv
// rtl/nibble_serial_sub16.sv - nibble-serial ripple-borrow subtractor, diff = a - b - bin
// One operation in flight; NIB bits per RUN cycle with the borrow registered between slices.
module nibble_serial_sub16 #(
  parameter int WIDTH = 16,
  parameter int NIB   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_sub16_if.slave bus
);

  localparam int STEPS = WIDTH / NIB;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] diff_q;
  logic             br_q;
  logic             bout_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt_q;

  logic [NIB-1:0]       slice_d;
  logic                 slice_bmsb;
  logic                 slice_bout;
  logic [WIDTH+NIB-1:0] diff_cat;
  logic                 accept;
  logic                 last_step;

  assign accept    = bus.in_valid && (state_q == IDLE);
  assign last_step = (state_q == RUN) && (cnt_q == LAST);

  // slice_bmsb is the borrow entering the top bit of the slice; on the final
  // step that is the borrow into bit WIDTH-1, needed for signed overflow.
  always_comb begin : slice
    logic bw;
    slice_d    = '0;
    slice_bmsb = 1'b0;
    bw         = br_q;
    for (int i = 0; i < NIB; i++) begin
      slice_d[i] = opa_q[i] ^ opb_q[i] ^ bw;
      if (i == NIB - 1) begin
        slice_bmsb = bw;
      end
      bw = (~opa_q[i] & opb_q[i]) | (~(opa_q[i] ^ opb_q[i]) & bw);
    end
    slice_bout = bw;
  end

  assign diff_cat = {slice_d, diff_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q  <= '0;
      opb_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      opa_q <= bus.a;
      opb_q <= bus.b;
      br_q  <= bus.bin;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      // Slice result enters from the MSB side, so after STEPS shifts the
      // first slice computed sits in the least significant nibble.
      diff_q <= diff_cat[WIDTH+NIB-1:NIB];
      opa_q  <= opa_q >> NIB;
      opb_q  <= opb_q >> NIB;
      br_q   <= slice_bout;
      cnt_q  <= cnt_q + CW'(1);
      if (last_step) begin
        bout_q <= slice_bout;
        ovf_q  <= slice_bmsb ^ slice_bout;
        cnt_q  <= '0;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// tb/tb_nibble_serial_sub16.sv - scoreboard bench for nibble_serial_sub16
module tb_nibble_serial_sub16;

  localparam int WIDTH = 16;
  localparam int NIB   = 4;
  localparam int STEPS = WIDTH / NIB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_sub16_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_sub16 #(.WIDTH(WIDTH), .NIB(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   last_acc = -1;
  logic prev_ov  = 1'b0;
  bit   done_tx  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin);
    exp_t             e;
    logic [WIDTH:0]   u;
    logic [WIDTH+1:0] s;
    u    = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bin);
    s    = {{2{a[WIDTH-1]}}, a} - {{2{b[WIDTH-1]}}, b} - (WIDTH+2)'(bin);
    e.d  = u[WIDTH-1:0];
    e.bo = u[WIDTH];
    e.ov = (s[WIDTH+1:WIDTH-1] != {3{s[WIDTH-1]}});
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    if (!rst_n) begin
      last_acc = -1;
      prev_ov  = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        if (last_acc >= 0) check("accept_spacing", 32'(cyc - last_acc >= STEPS + 2), 1);
        last_acc = cyc;
        acc_cyc  = cyc;
        sb.push_back(model(bus.a, bus.b, bus.bin));
      end
      if (bus.out_valid && !prev_ov) check("latency", cyc - acc_cyc - 1, STEPS);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("diff", bus.diff, e.d);
          check("bout", bus.bout, e.bo);
          check("ovf", bus.ovf, e.ov);
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    int n;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    bus.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = WIDTH'($urandom);
    bus.b        = WIDTH'($urandom);
    bus.bin      = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && bus.in_ready) break;
      n++;
      if (n > 100) begin
        check("drain_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      n++;
      if (n > 100) begin
        check("valid_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] va  [5] = '{16'h1234, 16'h0000, 16'h0005, 16'h8000, 16'h7FFF};
  logic [WIDTH-1:0] vb  [5] = '{16'h0234, 16'h0001, 16'h0005, 16'h0001, 16'hFFFF};
  logic             vbi [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [WIDTH-1:0] vd  [5] = '{16'h1000, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
  logic             vbo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic             vov [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    exp_t e;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_diff", bus.diff, 0);
    check("rst_bout", bus.bout, 0);
    check("rst_ovf", bus.ovf, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table constants cross-checked against the model, then run through the DUT.
    for (int i = 0; i < 5; i++) begin
      e = model(va[i], vb[i], vbi[i]);
      check("tbl_model", {e.d, e.bo, e.ov}, {vd[i], vbo[i], vov[i]});
      send(va[i], vb[i], vbi[i]);
      drain();
    end

    // Backpressure: result must hold while the upstream side churns.
    bus.out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'(i % 2);
      bus.a        = WIDTH'($urandom);
      bus.b        = WIDTH'($urandom);
      bus.bin      = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_diff", bus.diff, 16'h0123);
      check("bp_bout", bus.bout, 0);
      check("bp_ovf", bus.ovf, 0);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_after_valid", bus.out_valid, 0);
    check("bp_after_ready", bus.in_ready, 1);
    check("bp_sb_empty", sb.size(), 0);
    check("bp_hold_diff", bus.diff, 16'h0123);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // Reset two cycles into RUN drops the operation.
    send(16'h5555, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_diff", bus.diff, 0);
    check("mid_rst_bout", bus.bout, 0);
    check("mid_rst_ovf", bus.ovf, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    send(16'h00FF, 16'h000F, 1'b0);
    wait_valid();
    check("post_rst_diff", bus.diff, 16'h00F0);
    drain();

    // Random back-to-back traffic with random gaps and backpressure.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end
        done_tx = 1'b1;
      end
      begin
        n = 0;
        while (!done_tx || sb.size() != 0) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
          n++;
          if (n > 60000) begin
            check("random_timeout", 0, 1);
            break;
          end
        end
        bus.out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
